// File: rtl/axi4_stream_if.sv
// AXI4-Stream interface bundle.
// Parameterised on data, id, dest and user widths.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_upsizer.sv
// AXI4-Stream width upconverter: packs RATIO narrow beats into one
// wide beat; tlast flushes a partially filled word with zeroed lanes.
module axi4_stream_upsizer #(
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 128,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 1,
    parameter int USER_WIDTH_IN  = 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);
    localparam int RATIO = DATA_WIDTH_OUT / DATA_WIDTH_IN;
    localparam int KI    = DATA_WIDTH_IN / 8;
    localparam int KO    = DATA_WIDTH_OUT / 8;
    localparam int UO    = USER_WIDTH_IN * RATIO;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    if (DATA_WIDTH_OUT % DATA_WIDTH_IN != 0) begin : g_bad_mult
        $error("DATA_WIDTH_OUT must be a multiple of DATA_WIDTH_IN");
    end
    if (RATIO < 2) begin : g_bad_small
        $error("width ratio must be at least 2");
    end
    if ((RATIO & (RATIO - 1)) != 0) begin : g_bad_pow2
        $error("width ratio must be a power of 2");
    end

    logic                  rdy_en;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH_OUT-1:0] acc_data;
    logic [KO-1:0]         acc_strb;
    logic [KO-1:0]         acc_keep;
    logic [UO-1:0]         acc_user;
    logic [ID_WIDTH-1:0]   acc_id;
    logic [DEST_WIDTH-1:0] acc_dest;

    logic [DATA_WIDTH_OUT-1:0] w_data;
    logic [KO-1:0]         w_strb;
    logic [KO-1:0]         w_keep;
    logic [UO-1:0]         w_user;
    logic [ID_WIDTH-1:0]   w_id;
    logic [DEST_WIDTH-1:0] w_dest;

    logic                  o_valid;
    logic [DATA_WIDTH_OUT-1:0] o_data;
    logic [KO-1:0]         o_strb;
    logic [KO-1:0]         o_keep;
    logic [UO-1:0]         o_user;
    logic [ID_WIDTH-1:0]   o_id;
    logic [DEST_WIDTH-1:0] o_dest;
    logic                  o_last;

    logic accept;
    logic complete;

    assign pkt_i.tready = rdy_en && (!o_valid || pkt_o.tready);
    assign accept       = pkt_i.tvalid && pkt_i.tready;
    assign complete     = accept && (cnt == LAST_LANE || pkt_i.tlast);

    assign pkt_o.tvalid = o_valid;
    assign pkt_o.tdata  = o_data;
    assign pkt_o.tstrb  = o_strb;
    assign pkt_o.tkeep  = o_keep;
    assign pkt_o.tuser  = o_user;
    assign pkt_o.tid    = o_id;
    assign pkt_o.tdest  = o_dest;
    assign pkt_o.tlast  = o_last;

    // Accumulator contents with the current beat dropped into lane cnt.
    always_comb begin
        w_data = acc_data;
        w_strb = acc_strb;
        w_keep = acc_keep;
        w_user = acc_user;
        w_data[int'(cnt)*DATA_WIDTH_IN +: DATA_WIDTH_IN] = pkt_i.tdata;
        w_strb[int'(cnt)*KI +: KI] = pkt_i.tstrb;
        w_keep[int'(cnt)*KI +: KI] = pkt_i.tkeep;
        w_user[int'(cnt)*USER_WIDTH_IN +: USER_WIDTH_IN] = pkt_i.tuser;
        w_id   = (cnt == '0) ? pkt_i.tid   : acc_id;
        w_dest = (cnt == '0) ? pkt_i.tdest : acc_dest;
    end

    // Hold off input ready until the first cycle after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // Lane accumulator: clear on word completion, else fill next lane.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_strb <= '0;
            acc_keep <= '0;
            acc_user <= '0;
            acc_id   <= '0;
            acc_dest <= '0;
        end else if (complete) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_strb <= '0;
            acc_keep <= '0;
            acc_user <= '0;
            acc_id   <= '0;
            acc_dest <= '0;
        end else if (accept) begin
            cnt      <= cnt + CW'(1);
            acc_data <= w_data;
            acc_strb <= w_strb;
            acc_keep <= w_keep;
            acc_user <= w_user;
            acc_id   <= w_id;
            acc_dest <= w_dest;
        end
    end

    // Output register: load a finished word, drop valid once drained.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_strb  <= '0;
            o_keep  <= '0;
            o_user  <= '0;
            o_id    <= '0;
            o_dest  <= '0;
            o_last  <= 1'b0;
        end else if (complete) begin
            o_valid <= 1'b1;
            o_data  <= w_data;
            o_strb  <= w_strb;
            o_keep  <= w_keep;
            o_user  <= w_user;
            o_id    <= w_id;
            o_dest  <= w_dest;
            o_last  <= pkt_i.tlast;
        end else if (pkt_o.tready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4_stream_upsizer.sv
// Self-checking bench for axi4_stream_upsizer (32 -> 128 bits).
// Directed scenarios followed by randomized packets against a word model.
module tb_axi4_stream_upsizer;
    localparam int DI = 32;
    localparam int DO = 128;
    localparam int R  = 4;
    localparam int IW = 2;
    localparam int DW = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  k;
        logic        u;
        logic [1:0]  id;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  s;
        logic [15:0]  k;
        logic [3:0]   u;
        logic [1:0]   id;
        logic [1:0]   dest;
        logic         last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_WIDTH(DI), .ID_WIDTH(IW),
                     .DEST_WIDTH(DW), .USER_WIDTH(1)) si ();
    axi4_stream_if #(.DATA_WIDTH(DO), .ID_WIDTH(IW),
                     .DEST_WIDTH(DW), .USER_WIDTH(R)) so ();

    axi4_stream_upsizer #(
        .DATA_WIDTH_IN (DI),
        .DATA_WIDTH_OUT(DO),
        .ID_WIDTH      (IW),
        .DEST_WIDTH    (DW),
        .USER_WIDTH_IN (1)
    ) dut (
        .aclk   (clk),
        .aresetn(rst_n),
        .pkt_i  (si.slave),
        .pkt_o  (so.master)
    );

    int    tests = 0;
    int    fails = 0;
    beat_t inq[$];
    word_t expq[$];
    int    mlane = 0;
    word_t mw;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    got_cyc = 0;
    int    gotn = 0;
    int    accn = 0;
    int    lastn = 0;
    int    rdy_low = 0;
    word_t got;
    word_t held;
    logic  stalled = 1'b0;

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: group beats into words by count/tlast, place by shifting.
    function automatic void model_beat(input beat_t b);
        if (mlane == 0) begin
            mw      = '0;
            mw.id   = b.id;
            mw.dest = b.dest;
        end
        mw.d = mw.d | (128'(b.d) << (32 * mlane));
        mw.s = mw.s | (16'(b.s) << (4 * mlane));
        mw.k = mw.k | (16'(b.k) << (4 * mlane));
        mw.u = mw.u | (4'(b.u) << mlane);
        mlane++;
        if (mlane == R || b.last) begin
            mw.last = b.last;
            expq.push_back(mw);
            mlane = 0;
        end
    endfunction

    task automatic send(input beat_t b);
        inq.push_back(b);
        model_beat(b);
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic last);
        beat_t b;
        b      = '0;
        b.d    = d;
        b.s    = 4'hF;
        b.k    = 4'hF;
        b.last = last;
        return b;
    endfunction

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        b.d    = $urandom;
        b.s    = 4'($urandom);
        b.k    = 4'($urandom);
        b.u    = 1'($urandom);
        b.id   = 2'($urandom);
        b.dest = 2'($urandom);
        b.last = last;
        return b;
    endfunction

    function automatic word_t cur_out();
        word_t w;
        w.d    = so.tdata;
        w.s    = so.tstrb;
        w.k    = so.tkeep;
        w.u    = so.tuser;
        w.id   = so.tid;
        w.dest = so.tdest;
        w.last = so.tlast;
        return w;
    endfunction

    task automatic step(input logic ordy, input logic bubble);
        word_t w;
        @(negedge clk);
        so.tready = ordy;
        if (inq.size() > 0 && !bubble) begin
            si.tvalid = 1'b1;
            si.tdata  = inq[0].d;
            si.tstrb  = inq[0].s;
            si.tkeep  = inq[0].k;
            si.tuser  = inq[0].u;
            si.tid    = inq[0].id;
            si.tdest  = inq[0].dest;
            si.tlast  = inq[0].last;
        end else begin
            si.tvalid = 1'b0;
        end
        #1;
        cyc++;
        chk("tready_rule", si.tready, !so.tvalid || so.tready);
        w = cur_out();
        if (stalled) chk("stall_hold", w, held);
        stalled = so.tvalid && !so.tready;
        held    = w;
        if (so.tvalid && so.tready) begin
            if (expq.size() == 0) begin
                chk("extra_out", so.tvalid && so.tready, 1'b0);
            end else begin
                got     = w;
                got_cyc = cyc;
                gotn++;
                if (w.last) lastn++;
                chk("word", w, expq.pop_front());
            end
        end
        if (si.tvalid && si.tready) begin
            void'(inq.pop_front());
            acc_cyc = cyc;
            accn++;
        end
        if (!si.tready) rdy_low++;
    endtask

    task automatic drain(input bit rnd, output int n);
        n = 0;
        while (n < 3000 && (inq.size() > 0 || expq.size() > 0)) begin
            if (rnd) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            else     step(1'b1, 1'b0);
            n++;
        end
        chk("drain_done", 32'(inq.size() + expq.size()), 32'd0);
    endtask

    initial begin
        int n;
        int len;
        rst_n     = 1'b0;
        si.tvalid = 1'b0;
        si.tdata  = '0;
        si.tstrb  = '0;
        si.tkeep  = '0;
        si.tuser  = '0;
        si.tid    = '0;
        si.tdest  = '0;
        si.tlast  = 1'b0;
        so.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", so.tvalid, 1'b0);
        chk("rst_tdata", so.tdata, 128'd0);
        chk("rst_tkeep_tlast", {so.tkeep, so.tlast}, 17'd0);
        chk("rst_tready", si.tready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tready_at_release", si.tready, 1'b0);

        // 1: full packed word with tlast on lane 3
        send(mk(32'h11111111, 1'b0));
        send(mk(32'h22222222, 1'b0));
        send(mk(32'h33333333, 1'b0));
        send(mk(32'h44444444, 1'b1));
        drain(1'b0, n);
        chk("t1_data", got.d, 128'h44444444_33333333_22222222_11111111);
        chk("t1_keep_last", {got.k, got.last}, {16'hFFFF, 1'b1});
        chk("t1_latency", 32'(got_cyc - acc_cyc), 32'd1);
        chk("t1_count", 32'(gotn), 32'd1);

        // 2: two-beat flush
        send(mk(32'hAAAAAAAA, 1'b0));
        send(mk(32'hBBBBBBBB, 1'b1));
        drain(1'b0, n);
        chk("t2_data", got.d, 128'h0_BBBBBBBB_AAAAAAAA);
        chk("t2_keep_last", {got.k, got.last}, {16'h00FF, 1'b1});

        // 3: 64-beat packet at full rate
        gotn    = 0;
        lastn   = 0;
        rdy_low = 0;
        for (int i = 0; i < 64; i++) send(rnd_beat(i == 63));
        drain(1'b0, n);
        chk("t3_outputs", 32'(gotn), 32'd16);
        chk("t3_cycles", 32'(n), 32'd65);
        chk("t3_tready_low", 32'(rdy_low), 32'd0);
        chk("t3_lasts", {32'(lastn), got.last}, {32'd1, 1'b1});

        // 4: sink stalls for 10 cycles
        accn = 0;
        for (int i = 0; i < 12; i++) send(rnd_beat(i == 11));
        repeat (10) step(1'b0, 1'b0);
        chk("t4_stall_accepts", 32'(accn), 32'd4);
        chk("t4_stall_tready", si.tready, 1'b0);
        drain(1'b0, n);

        // 5: reset after two accepted beats
        send(mk(32'hDEAD0001, 1'b0));
        send(mk(32'hDEAD0002, 1'b0));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        si.tvalid = 1'b0;
        #1;
        chk("t5_rst_tvalid", so.tvalid, 1'b0);
        chk("t5_rst_tready", si.tready, 1'b0);
        inq.delete();
        expq.delete();
        mlane   = 0;
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(mk(32'h1, 1'b0));
        send(mk(32'h2, 1'b0));
        send(mk(32'h3, 1'b0));
        send(mk(32'h4, 1'b1));
        drain(1'b0, n);
        chk("t5_data", got.d, 128'h00000004_00000003_00000002_00000001);

        // 6: tuser/tid taken from their lanes / lane 0
        begin
            beat_t b;
            b      = mk(32'h5, 1'b0);
            b.u    = 1'b1;
            b.id   = 2'd3;
            b.dest = 2'd1;
            send(b);
            send(mk(32'h6, 1'b0));
            send(mk(32'h7, 1'b0));
            send(mk(32'h8, 1'b1));
        end
        drain(1'b0, n);
        chk("t6_user", got.u, 4'b0001);
        chk("t6_id_dest", {got.id, got.dest}, {2'd3, 2'd1});

        // random packets, random backpressure and bubbles
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) send(rnd_beat(i == len - 1));
            drain(1'b1, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
